// File: rtl/seq_scan_arbiter.sv
// seq_scan_arbiter: round-robin scheduler that lends one serial sequence
// detector to four requesters. Each granted word is flushed into the detector
// MSB-first and the first MATCH position is reported back with the job ID.
module seq_scan_arbiter #(
  parameter int W = 8
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [3:0]     REQ,
  input  logic [4*W-1:0] REQ_DATA,
  output logic [3:0]     GNT,
  output logic           BUSY,
  output logic           DET_RST,
  output logic           DET_IN,
  input  logic           DET_MATCH,
  output logic           DONE,
  output logic [1:0]     DONE_ID,
  output logic           HIT,
  output logic [5:0]     HIT_POS
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FLUSH  = 3'd1;
  localparam logic [2:0] SHIFT  = 3'd2;
  localparam logic [2:0] DRAIN  = 3'd3;
  localparam logic [2:0] REPORT = 3'd4;

  localparam logic [5:0] W6 = 6'(W);

  logic [2:0]   state_reg;
  logic [1:0]   last_gnt_reg;
  logic [1:0]   job_id_reg;
  logic [W-1:0] shift_reg;
  logic [5:0]   bit_cnt_reg;
  logic         hit_flag_reg;
  logic [5:0]   hit_pos_reg;

  // Per-requester word view of the packed request bus.
  logic [W-1:0] words [4];
  for (genvar gi = 0; gi < 4; gi++) begin : g_words
    assign words[gi] = REQ_DATA[gi*W +: W];
  end

  // Rotate requests so bit 0 is the requester right after the last grant.
  logic [7:0] req_dbl;
  logic [2:0] rot_base;
  logic [3:0] req_rot;
  logic [1:0] win_off;
  logic [1:0] win_id;

  assign req_dbl  = {REQ, REQ};
  assign rot_base = {1'b0, last_gnt_reg} + 3'd1;
  assign req_rot  = req_dbl[rot_base +: 4];

  // Priority pick within the rotated request vector.
  always_comb begin
    win_off = 2'd3;
    if (req_rot[0])      win_off = 2'd0;
    else if (req_rot[1]) win_off = 2'd1;
    else if (req_rot[2]) win_off = 2'd2;
  end

  assign win_id = last_gnt_reg + 2'd1 + win_off;

  // Job sequencer: grant, flush detector, shift word, drain, report.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg    <= IDLE;
      last_gnt_reg <= 2'd3;
      job_id_reg   <= 2'd0;
      shift_reg    <= '0;
      bit_cnt_reg  <= 6'd0;
      hit_flag_reg <= 1'b0;
      hit_pos_reg  <= 6'd0;
      GNT          <= 4'b0000;
      BUSY         <= 1'b0;
      DET_RST      <= 1'b1;
      DET_IN       <= 1'b0;
      DONE         <= 1'b0;
      DONE_ID      <= 2'd0;
      HIT          <= 1'b0;
      HIT_POS      <= 6'd0;
    end else begin
      GNT  <= 4'b0000;
      DONE <= 1'b0;
      case (state_reg)
        IDLE: begin
          DET_IN  <= 1'b0;
          DET_RST <= 1'b0;
          // The first IDLE cycle after reset only releases the detector;
          // arbitration starts once DET_RST has dropped.
          if (!DET_RST && (|REQ)) begin
            shift_reg    <= words[win_id];
            job_id_reg   <= win_id;
            last_gnt_reg <= win_id;
            GNT          <= 4'b0001 << win_id;
            DET_RST      <= 1'b1;
            BUSY         <= 1'b1;
            hit_flag_reg <= 1'b0;
            hit_pos_reg  <= 6'd0;
            state_reg    <= FLUSH;
          end
        end
        FLUSH: begin
          DET_RST     <= 1'b0;
          DET_IN      <= shift_reg[W-1];
          shift_reg   <= shift_reg << 1;
          bit_cnt_reg <= 6'd1;
          state_reg   <= SHIFT;
        end
        SHIFT: begin
          // MATCH in cycle k reflects the k-1 bits already clocked in;
          // at k=1 the detector is just out of reset, so it is ignored.
          if ((bit_cnt_reg >= 6'd2) && DET_MATCH && !hit_flag_reg) begin
            hit_flag_reg <= 1'b1;
            hit_pos_reg  <= bit_cnt_reg - 6'd1;
          end
          if (bit_cnt_reg == W6) begin
            DET_IN    <= 1'b0;
            state_reg <= DRAIN;
          end else begin
            DET_IN      <= shift_reg[W-1];
            shift_reg   <= shift_reg << 1;
            bit_cnt_reg <= bit_cnt_reg + 6'd1;
          end
        end
        DRAIN: begin
          DONE      <= 1'b1;
          DONE_ID   <= job_id_reg;
          state_reg <= REPORT;
          if (hit_flag_reg) begin
            HIT     <= 1'b1;
            HIT_POS <= hit_pos_reg;
          end else if (DET_MATCH) begin
            HIT     <= 1'b1;
            HIT_POS <= W6;
          end else begin
            HIT     <= 1'b0;
            HIT_POS <= 6'd0;
          end
        end
        REPORT: begin
          BUSY      <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          BUSY      <= 1'b0;
          DET_RST   <= 1'b1;
          DET_IN    <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_scan_arbiter.sv
// Testbench for seq_scan_arbiter: table-driven single jobs plus hand-written
// reset / round-robin / mid-job-reset sequences, checked via scoreboard queues.
module tb_seq_scan_arbiter;

  localparam int W = 8;

  logic           CLK;
  logic           RST;
  logic [3:0]     REQ;
  logic [4*W-1:0] REQ_DATA;
  logic [3:0]     GNT;
  logic           BUSY;
  logic           DET_RST;
  logic           DET_IN;
  logic           DET_MATCH;
  logic           DONE;
  logic [1:0]     DONE_ID;
  logic           HIT;
  logic [5:0]     HIT_POS;

  logic [W-1:0] tb_words [4];
  assign REQ_DATA = {tb_words[3], tb_words[2], tb_words[1], tb_words[0]};

  seq_scan_arbiter #(.W(W)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_DATA(REQ_DATA), .GNT(GNT),
    .BUSY(BUSY), .DET_RST(DET_RST), .DET_IN(DET_IN), .DET_MATCH(DET_MATCH),
    .DONE(DONE), .DONE_ID(DONE_ID), .HIT(HIT), .HIT_POS(HIT_POS)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0] id;
    logic       hit;
    logic [5:0] pos;
    int         due;
  } res_t;

  typedef struct {
    logic [3:0]   req;
    logic [W-1:0] data;
    logic [15:0]  mask;
    logic [1:0]   id;
    logic         hit;
    logic [5:0]   pos;
  } vec_t;

  res_t   res_q[$];
  int     gnt_q[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     jc = 0;
  int     last_gnt_cyc = 0;
  int     rel_cyc = 0;
  bit     spacing_chk = 0;
  bit     first_chk = 0;
  logic [15:0]  match_mask = '0;
  logic [W-1:0] job_data = '0;
  logic         exp_hit_cur = 1'b0;
  logic [5:0]   exp_pos_cur = 6'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  // One clock: observe outputs after the edge, score them, drive the MATCH stub.
  task automatic step();
    int   g;
    res_t r;
    @(posedge CLK);
    #1;
    cyc++;
    if (RST) begin
      if (GNT !== 4'b0000) begin
        g = 0;
        for (int i = 0; i < 4; i++) if (GNT[i]) g = i;
        if (gnt_q.size() == 0) begin
          fail("unexpected_gnt");
        end else begin
          g = gnt_q.pop_front();
          check("gnt", 32'(GNT), 32'(4'b0001 << g));
          $display("GNT cycle %0d gnt=%b", cyc, GNT);
        end
        if (first_chk) begin
          check("first_gnt_latency", 32'(cyc - rel_cyc), 32'd2);
          first_chk = 0;
        end
        if (spacing_chk && last_gnt_cyc > 0)
          check("gnt_spacing", 32'(cyc - last_gnt_cyc), 32'(W + 4));
        last_gnt_cyc = cyc;
        jc = 1;
        job_data = tb_words[g];
        r.id = 2'(g); r.hit = exp_hit_cur; r.pos = exp_pos_cur; r.due = cyc + W + 2;
        res_q.push_back(r);
        if (gnt_q.size() == 0) REQ = 4'b0000;
      end else if (jc > 0) begin
        jc++;
      end
      check("busy", 32'(BUSY), 32'(jc != 0));
      if (jc == 1)
        check("det_rst_flush", 32'(DET_RST), 32'd1);
      else if (jc >= 2 && jc <= W + 1)
        check("det_in_bit", 32'(DET_IN), 32'(job_data[W - (jc - 1)]));
      else if (jc == W + 2)
        check("det_in_drain", 32'(DET_IN), 32'd0);
      if (DONE === 1'b1) begin
        if (res_q.size() == 0) begin
          fail("unexpected_done");
        end else begin
          r = res_q.pop_front();
          check("done_id", 32'(DONE_ID), 32'(r.id));
          check("hit", 32'(HIT), 32'(r.hit));
          check("hit_pos", 32'(HIT_POS), 32'(r.pos));
          check("done_cycle", 32'(cyc), 32'(r.due));
          $display("DONE cycle %0d id=%0d hit=%0d pos=%0d", cyc, DONE_ID, HIT, HIT_POS);
        end
      end
      if (jc == W + 3) jc = 0;
    end
    DET_MATCH = (jc >= 1 && jc <= 15) ? match_mask[jc] : 1'b0;
  endtask

  // Run until all expected grants and results are consumed, bounded.
  task automatic wait_jobs(input int limit);
    int n;
    n = 0;
    while ((gnt_q.size() != 0 || res_q.size() != 0 || jc != 0) && n < limit) begin
      step();
      n++;
    end
    if (n >= limit) begin
      fail("wait_jobs_timeout");
      gnt_q.delete();
      res_q.delete();
      jc = 0;
      REQ = 4'b0000;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_det_rst"}, 32'(DET_RST), 32'd1);
    check({tag, "_gnt"},     32'(GNT),     32'd0);
    check({tag, "_busy"},    32'(BUSY),    32'd0);
    check({tag, "_det_in"},  32'(DET_IN),  32'd0);
    check({tag, "_done"},    32'(DONE),    32'd0);
    check({tag, "_done_id"}, 32'(DONE_ID), 32'd0);
    check({tag, "_hit"},     32'(HIT),     32'd0);
    check({tag, "_hit_pos"}, 32'(HIT_POS), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [6];
    int n;
    vecs[0] = '{4'b0100, 8'b11100011, 16'h1 << 9,            2'd2, 1'b1, 6'd7};
    vecs[1] = '{4'b0001, 8'h5A,       16'h1 << 10,           2'd0, 1'b1, 6'd8};
    vecs[2] = '{4'b0010, 8'hC3,       (16'h1 << 5) | (16'h1 << 7), 2'd1, 1'b1, 6'd3};
    vecs[3] = '{4'b1000, 8'h0F,       16'h0,                 2'd3, 1'b0, 6'd0};
    vecs[4] = '{4'b0001, 8'h81,       16'h1 << 2,            2'd0, 1'b0, 6'd0};
    vecs[5] = '{4'b0100, 8'h6E,       16'h1 << 3,            2'd2, 1'b1, 6'd1};

    RST = 1'b0;
    REQ = 4'b1111;
    DET_MATCH = 1'b0;
    tb_words[0] = 8'hA5; tb_words[1] = 8'h3C; tb_words[2] = 8'hF0; tb_words[3] = 8'h96;

    // Reset held with all requests pending: detector in reset, nothing granted.
    for (int i = 0; i < 3; i++) step();
    check_reset_outputs("reset");

    // Release; requests held continuously give round robin 0,1,2,3,0.
    gnt_q.push_back(0); gnt_q.push_back(1); gnt_q.push_back(2);
    gnt_q.push_back(3); gnt_q.push_back(0);
    exp_hit_cur = 1'b0; exp_pos_cur = 6'd0; match_mask = '0;
    RST = 1'b1;
    rel_cyc = cyc;
    first_chk = 1;
    spacing_chk = 1;
    last_gnt_cyc = 0;
    step();
    check("release_det_rst", 32'(DET_RST), 32'd0);
    check("release_no_gnt", 32'(GNT), 32'd0);
    wait_jobs(100);
    spacing_chk = 0;

    // Table-driven single jobs: hit positions, drain hit, first-only, no hit.
    for (int v = 0; v < 6; v++) begin
      tb_words[vecs[v].id] = vecs[v].data;
      match_mask  = vecs[v].mask;
      exp_hit_cur = vecs[v].hit;
      exp_pos_cur = vecs[v].pos;
      gnt_q.push_back(int'(vecs[v].id));
      REQ = vecs[v].req;
      wait_jobs(40);
    end

    // Mid-job reset at SHIFT k=4: immediate return to reset values, no DONE.
    match_mask = 16'h1 << 3;
    exp_hit_cur = 1'b1; exp_pos_cur = 6'd1;
    tb_words[0] = 8'hB7;
    gnt_q.push_back(0);
    REQ = 4'b0001;
    n = 0;
    while (jc != 5 && n < 40) begin
      step();
      n++;
    end
    if (n >= 40) fail("midreset_reach_k4");
    RST = 1'b0;
    #1;
    check_reset_outputs("midreset");
    jc = 0;
    res_q.delete();
    gnt_q.delete();
    DET_MATCH = 1'b0;
    match_mask = '0;
    REQ = 4'b1010;
    for (int i = 0; i < 2; i++) begin
      step();
      check("midreset_no_done", 32'(DONE), 32'd0);
    end

    // After release last_gnt is 3 again: REQ[1] wins over REQ[3], then 3 follows.
    exp_hit_cur = 1'b0; exp_pos_cur = 6'd0;
    gnt_q.push_back(1);
    gnt_q.push_back(3);
    RST = 1'b1;
    rel_cyc = cyc;
    first_chk = 1;
    wait_jobs(60);

    for (int i = 0; i < 4; i++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
